// File: rtl/vga_sync_if.sv
// ============================================================================
// Module      : vga_sync_if
// Description : Pixel-side bundle between the VGA timing generator and its
//               overlay/DAC consumers.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_sync_if;
    logic [11:0] rgb_in;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        p_tick;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [11:0] rgb_out;

    modport master (
        input  rgb_in,
        output pixel_x, pixel_y, p_tick, video_on,
        output hsync, vsync, frame_start, rgb_out
    );

    modport slave (
        output rgb_in,
        input  pixel_x, pixel_y, p_tick, video_on,
        input  hsync, vsync, frame_start, rgb_out
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : 640x480@60 VGA timing generator with pixel strobe, sync pins,
//               frame pulse and a registered, blanked RGB output stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  wire          clk,
    input  wire          reset,
    vga_sync_if.master   bus
);

    localparam int DIV_W = $clog2(TICK_DIV);

    localparam int          c_h_total    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int          c_v_total    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0]  c_h_last     = 10'(c_h_total - 1);
    localparam logic [9:0]  c_v_last     = 10'(c_v_total - 1);
    localparam logic [9:0]  c_h_disp     = 10'(H_DISPLAY);
    localparam logic [9:0]  c_v_disp     = 10'(V_DISPLAY);
    localparam logic [9:0]  c_hs_start   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0]  c_hs_end     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  c_vs_start   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  c_vs_end     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_start;
    logic [11:0]      r_rgb;

    logic             w_tick;
    logic             w_h_end;
    logic             w_v_end;
    logic             w_video_on;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;

    assign w_tick     = (r_div_cnt == c_div_last);
    assign w_h_end    = (r_h == c_h_last);
    assign w_v_end    = (r_v == c_v_last);
    assign w_video_on = (r_h < c_h_disp) && (r_v < c_v_disp);

    // Next-state counters feed the sync registers so sync lines up with the
    // coordinates they describe rather than lagging them by one clock.
    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (w_tick) begin
            w_h_next = w_h_end ? 10'd0 : r_h + 10'd1;
            if (w_h_end) begin
                w_v_next = w_v_end ? 10'd0 : r_v + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
            r_rgb         <= 12'h000;
        end else begin
            r_div_cnt     <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hsync       <= !((w_h_next >= c_hs_start) && (w_h_next <= c_hs_end));
            r_vsync       <= !((w_v_next >= c_vs_start) && (w_v_next <= c_vs_end));
            r_frame_start <= w_tick && w_h_end && w_v_end;
            r_rgb         <= w_video_on ? bus.rgb_in : 12'h000;
        end
    end

    assign bus.pixel_x     = r_h;
    assign bus.pixel_y     = r_v;
    assign bus.p_tick      = w_tick;
    assign bus.video_on    = w_video_on;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.frame_start = r_frame_start;
    assign bus.rgb_out     = r_rgb;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen: full-size instance for
//               line timing, reduced-size instance for whole-frame behaviour.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

    typedef struct {
        int x;
        int y;
        int tick;
        int von;
        int hs;
        int vs;
        int fs;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [11:0] rgb_in;
    logic [11:0] rgb_q;
    int          n_cnt;
    bit          started;
    int          n_vec;
    int          n_err;
    int          fs_count;

    vga_sync_if bus_a ();
    vga_sync_if bus_b ();

    assign bus_a.rgb_in = rgb_in;
    assign bus_b.rgb_in = rgb_in;

    vga_sync_gen u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    vga_sync_gen #(
        .H_DISPLAY (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
        .V_DISPLAY (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .TICK_DIV  (3)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timing as a pure function of clocks elapsed since reset: n edges give
    // n/td consumed pixel ticks, which fold into (h, v) positions.
    function automatic exp_t model(input int n, input int hd, input int hf,
                                   input int hs, input int hb, input int vd,
                                   input int vf, input int vs, input int vb,
                                   input int td);
        exp_t e;
        int ht, vt, k, h, v;
        ht     = hd + hf + hs + hb;
        vt     = vd + vf + vs + vb;
        k      = n / td;
        h      = k % ht;
        v      = (k / ht) % vt;
        e.x    = h;
        e.y    = v;
        e.tick = (n % td == td - 1) ? 1 : 0;
        e.von  = (h < hd && v < vd) ? 1 : 0;
        e.hs   = (h >= hd + hf && h < hd + hf + hs) ? 0 : 1;
        e.vs   = (v >= vd + vf && v < vd + vf + vs) ? 0 : 1;
        e.fs   = (n > 0 && n % td == 0 && k % (ht * vt) == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic exp_t model_a(input int n);
        return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    endfunction

    function automatic exp_t model_b(input int n);
        return model(n, 16, 4, 6, 4, 8, 2, 2, 3, 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", nm, act, exp, n_cnt, $time);
        end
    endtask

    always @(posedge clk) begin
        rgb_q <= rgb_in;
        if (reset) begin
            n_cnt   <= 0;
            started <= 1'b1;
        end else begin
            n_cnt <= n_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            exp_t ea, eb;
            exp_t pa, pb;
            ea = model_a(n_cnt);
            eb = model_b(n_cnt);
            pa = model_a(n_cnt - 1);
            pb = model_b(n_cnt - 1);
            chk("a.pixel_x",     32'(bus_a.pixel_x),     32'(ea.x));
            chk("a.pixel_y",     32'(bus_a.pixel_y),     32'(ea.y));
            chk("a.p_tick",      32'(bus_a.p_tick),      32'(ea.tick));
            chk("a.video_on",    32'(bus_a.video_on),    32'(ea.von));
            chk("a.hsync",       32'(bus_a.hsync),       32'(ea.hs));
            chk("a.vsync",       32'(bus_a.vsync),       32'(ea.vs));
            chk("a.frame_start", 32'(bus_a.frame_start), 32'(ea.fs));
            chk("a.rgb_out",     32'(bus_a.rgb_out),
                32'((n_cnt > 0 && pa.von == 1) ? rgb_q : 12'h000));
            chk("b.pixel_x",     32'(bus_b.pixel_x),     32'(eb.x));
            chk("b.pixel_y",     32'(bus_b.pixel_y),     32'(eb.y));
            chk("b.p_tick",      32'(bus_b.p_tick),      32'(eb.tick));
            chk("b.video_on",    32'(bus_b.video_on),    32'(eb.von));
            chk("b.hsync",       32'(bus_b.hsync),       32'(eb.hs));
            chk("b.vsync",       32'(bus_b.vsync),       32'(eb.vs));
            chk("b.frame_start", 32'(bus_b.frame_start), 32'(eb.fs));
            chk("b.rgb_out",     32'(bus_b.rgb_out),
                32'((n_cnt > 0 && pb.von == 1) ? rgb_q : 12'h000));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_a(input int x, input int y, input int budget, input string nm);
        int i;
        i = 0;
        while (!(bus_a.pixel_x == 10'(x) && bus_a.pixel_y == 10'(y)) && i < budget) begin
            step();
            i++;
        end
        chk({nm, ".reached"}, 32'(i < budget), 32'd1);
    endtask

    initial begin
        exp_t m;
        n_vec    = 0;
        n_err    = 0;
        fs_count = 0;
        started  = 1'b0;
        n_cnt    = 0;
        reset    = 1'b1;
        rgb_in   = 12'hABC;

        // Hand-derived anchors for the model itself.
        m = model_a(656 * 4);
        chk("model.hs_656", 32'(m.hs), 32'd0);
        m = model_a(752 * 4);
        chk("model.hs_752", 32'(m.hs), 32'd1);
        m = model_a(800 * 4);
        chk("model.wrap_y", 32'(m.y), 32'd1);
        m = model_a(800 * 490 * 4);
        chk("model.vs_490", 32'(m.vs), 32'd0);

        repeat (3) step();
        chk("rst.pixel_x",     32'(bus_a.pixel_x),     32'd0);
        chk("rst.pixel_y",     32'(bus_a.pixel_y),     32'd0);
        chk("rst.hsync",       32'(bus_a.hsync),       32'd1);
        chk("rst.vsync",       32'(bus_a.vsync),       32'd1);
        chk("rst.rgb_out",     32'(bus_a.rgb_out),     32'h000);
        chk("rst.frame_start", 32'(bus_a.frame_start), 32'd0);
        chk("rst.p_tick",      32'(bus_a.p_tick),      32'd0);
        chk("rst.video_on",    32'(bus_a.video_on),    32'd1);

        reset = 1'b0;
        step(); step();
        chk("tick.n2",  32'(bus_a.p_tick),  32'd0);
        step();
        chk("tick.n3",  32'(bus_a.p_tick),  32'd1);
        chk("px.n3",    32'(bus_a.pixel_x), 32'd0);
        step();
        chk("tick.n4",  32'(bus_a.p_tick),  32'd0);
        chk("px.n4",    32'(bus_a.pixel_x), 32'd1);
        chk("rgb.n4",   32'(bus_a.rgb_out), 32'hABC);

        wait_a(640, 0, 4000, "x640");
        step();
        chk("blank.640", 32'(bus_a.rgb_out), 32'h000);
        wait_a(656, 0, 4000, "x656");
        chk("hs.656",  32'(bus_a.hsync), 32'd0);
        wait_a(752, 0, 4000, "x752");
        chk("hs.752",  32'(bus_a.hsync), 32'd1);
        wait_a(0, 1, 4000, "line1");
        chk("line1.x", 32'(bus_a.pixel_x), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            rgb_in = 12'((i * 37 + 5) ^ (i << 4));
            step();
        end
        rgb_in = 12'hABC;

        wait_a(700, 1, 4000, "x700");
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid.pixel_x",     32'(bus_a.pixel_x),     32'd0);
        chk("mid.pixel_y",     32'(bus_a.pixel_y),     32'd0);
        chk("mid.hsync",       32'(bus_a.hsync),       32'd1);
        chk("mid.rgb_out",     32'(bus_a.rgb_out),     32'h000);
        chk("mid.p_tick",      32'(bus_a.p_tick),      32'd0);
        chk("mid.b.pixel_x",   32'(bus_b.pixel_x),     32'd0);

        // Reduced instance: 30x15 positions at 3 clocks each = 1350 clocks
        // per frame, so 8000 clocks hold five frame pulses.
        for (int i = 0; i < 8000; i++) begin
            if (i % 7 == 3) rgb_in = 12'(i * 11);
            step();
            if (bus_b.frame_start === 1'b1) fs_count++;
        end
        chk("b.frame_count", 32'(fs_count), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
